// File: rtl/usb3_slfifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : usb3_slfifo_rd_ctrl_if
// Description : FX3 slave-FIFO read-side bundle. The master modport is the
//               read controller; the slave modport is the FX3 and cache side.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb3_slfifo_rd_ctrl_if;
    logic        USB3_FLAGA;
    logic [31:0] USB3_DQ;
    logic        cache_ready;
    logic        SLCS_n;
    logic        SLOE_n;
    logic        SLRD_n;
    logic [1:0]  FIFOADR;
    logic [3:0]  usb_rd_state;
    logic [31:0] data_out;
    logic        data_valid;
    logic        burst_done;
    logic        rd_abort;

    modport master (
        input  USB3_FLAGA, USB3_DQ, cache_ready,
        output SLCS_n, SLOE_n, SLRD_n, FIFOADR, usb_rd_state,
               data_out, data_valid, burst_done, rd_abort
    );

    modport slave (
        output USB3_FLAGA, USB3_DQ, cache_ready,
        input  SLCS_n, SLOE_n, SLRD_n, FIFOADR, usb_rd_state,
               data_out, data_valid, burst_done, rd_abort
    );
endinterface
`default_nettype wire

// File: rtl/usb3_slfifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb3_slfifo_rd_ctrl
// Description : Burst read master for the FX3 slave FIFO. Reads BURST_LEN
//               words from the read socket when FLAGA and cache_ready allow,
//               aligns returning data through a RD_LATENCY-deep pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module usb3_slfifo_rd_ctrl #(
    parameter int         BURST_LEN  = 256,
    parameter int         RD_LATENCY = 2,
    parameter int         GAP_CYCLES = 4,
    parameter logic [1:0] RD_SOCKET  = 2'b11
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    usb3_slfifo_rd_ctrl_if.master bus
);

    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CHK   = 4'd3;
    localparam logic [3:0] S_OE    = 4'd4;
    localparam logic [3:0] S_SETUP = 4'd5;
    localparam logic [3:0] S_READ  = 4'd6;
    localparam logic [3:0] S_DRAIN = 4'd7;
    localparam logic [3:0] S_GAP   = 4'd8;

    localparam logic [CW-1:0] C_RD_LAST    = CW'(BURST_LEN - 1);
    localparam logic [GW-1:0] C_GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [1:0]    C_DRAIN_LAST = 2'(RD_LATENCY - 1);

    logic [3:0]            r_state;
    logic [CW-1:0]         r_rd_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic [1:0]            r_drain_cnt;
    logic                  r_slcs_n;
    logic                  r_sloe_n;
    logic                  r_slrd_n;
    logic [1:0]            r_fifoadr;
    logic                  r_burst_done;
    logic                  r_rd_abort;
    logic [RD_LATENCY-1:0] r_pipe;
    logic [RD_LATENCY-1:0] w_pipe_next;
    logic [31:0]           r_data_out;

    // The pipe head is the strobe currently on the wire; the tail of the
    // next pipe value marks the cycle whose DQ word becomes data_out.
    generate
        if (RD_LATENCY == 1) begin : g_lat_one
            assign w_pipe_next = ~r_slrd_n;
        end else begin : g_lat_multi
            assign w_pipe_next = {r_pipe[RD_LATENCY-2:0], ~r_slrd_n};
        end
    endgenerate

    // Burst sequencing and FX3 strobe generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rd_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_slcs_n     <= 1'b1;
            r_sloe_n     <= 1'b1;
            r_slrd_n     <= 1'b1;
            r_fifoadr    <= RD_SOCKET;
            r_burst_done <= 1'b0;
            r_rd_abort   <= 1'b0;
        end else begin
            r_fifoadr    <= RD_SOCKET;
            r_burst_done <= 1'b0;
            r_rd_abort   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_slcs_n <= 1'b1;
                    r_sloe_n <= 1'b1;
                    r_slrd_n <= 1'b1;
                    if (bus.USB3_FLAGA && bus.cache_ready) begin
                        r_state  <= S_CHK;
                        r_slcs_n <= 1'b0;
                    end
                end
                S_CHK: begin
                    // Re-qualify FLAGA once the chip is selected; a one-cycle
                    // glitch backs out before OE is ever driven.
                    if (!bus.USB3_FLAGA) begin
                        r_state  <= S_IDLE;
                        r_slcs_n <= 1'b1;
                    end else begin
                        r_state  <= S_OE;
                        r_sloe_n <= 1'b0;
                    end
                end
                S_OE: begin
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_slrd_n <= 1'b0;
                    r_rd_cnt <= '0;
                    r_state  <= S_READ;
                end
                S_READ: begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    // The strobe of this cycle counts even when FLAGA is
                    // seen low; abort wins over the last-word case.
                    if (!bus.USB3_FLAGA || (r_rd_cnt == C_RD_LAST)) begin
                        r_slrd_n    <= 1'b1;
                        r_drain_cnt <= '0;
                        r_rd_abort  <= ~bus.USB3_FLAGA;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                    if (r_drain_cnt == C_DRAIN_LAST) begin
                        r_state      <= S_GAP;
                        r_gap_cnt    <= '0;
                        r_burst_done <= 1'b1;
                        r_sloe_n     <= 1'b1;
                        r_slcs_n     <= 1'b1;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                    if (r_gap_cnt == C_GAP_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_slcs_n <= 1'b1;
                    r_sloe_n <= 1'b1;
                    r_slrd_n <= 1'b1;
                end
            endcase
        end
    end

    // Latency pipe: capture DQ so data_out and data_valid appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe     <= '0;
            r_data_out <= '0;
        end else begin
            r_pipe <= w_pipe_next;
            if (w_pipe_next[RD_LATENCY-1]) begin
                r_data_out <= bus.USB3_DQ;
            end
        end
    end

    assign bus.SLCS_n       = r_slcs_n;
    assign bus.SLOE_n       = r_sloe_n;
    assign bus.SLRD_n       = r_slrd_n;
    assign bus.FIFOADR      = r_fifoadr;
    assign bus.usb_rd_state = r_state;
    assign bus.data_out     = r_data_out;
    assign bus.data_valid   = r_pipe[RD_LATENCY-1];
    assign bus.burst_done   = r_burst_done;
    assign bus.rd_abort     = r_rd_abort;

endmodule
`default_nettype wire

// File: tb/tb_usb3_slfifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb3_slfifo_rd_ctrl
// Description : Self-checking bench with an FX3 read-socket model and a
//               word scoreboard; randomized abort points and cache_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb3_slfifo_rd_ctrl;

    localparam int B   = 256;
    localparam int LAT = 2;
    localparam int GAP = 4;

    logic clk;
    logic rst_n;

    usb3_slfifo_rd_ctrl_if bus ();

    usb3_slfifo_rd_ctrl #(
        .BURST_LEN  (B),
        .RD_LATENCY (LAT),
        .GAP_CYCLES (GAP),
        .RD_SOCKET  (2'b11)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FX3 model / monitor state (written only by the monitor process)
    bit          hist [LAT];
    logic [31:0] exp_q [$];
    logic [31:0] fx3_word = 0;
    int cyc = 0, rise_cyc = 0, chk_prev = 0, chk_last = 0;
    int rd_low_cnt = 0, dv_cnt = 0, bd_cnt = 0, ab_cnt = 0, oe_low_cnt = 0;
    logic       prev_rd_n = 1'b1;
    logic [3:0] prev_state = 4'd0;

    // FX3 model: a strobe sampled low returns its word LAT cycles later.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) hist[i] = 1'b0;
            exp_q.delete();
            fx3_word   = 0;
            bus.USB3_DQ = $urandom;
            prev_rd_n  = 1'b1;
            prev_state = 4'd0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = (bus.SLRD_n == 1'b0);
            if (hist[LAT-1]) begin
                bus.USB3_DQ = fx3_word;
                exp_q.push_back(fx3_word);
                fx3_word++;
            end else begin
                bus.USB3_DQ = $urandom;
            end
            if (bus.SLRD_n == 1'b0) begin
                rd_low_cnt++;
                check("cs_oe_low_while_rd", {30'd0, bus.SLCS_n, bus.SLOE_n}, 0);
            end
            if (prev_rd_n == 1'b0 && bus.SLRD_n == 1'b1) rise_cyc = cyc;
            if (bus.data_valid) begin
                dv_cnt++;
                if (exp_q.size() == 0) check("dv_without_read", 1, 0);
                else check("data_out", bus.data_out, exp_q.pop_front());
            end
            if (bus.burst_done) begin
                bd_cnt++;
                check("burst_done_after_rd_rise", cyc - rise_cyc, LAT);
            end
            if (bus.rd_abort) ab_cnt++;
            if (bus.SLOE_n == 1'b0) oe_low_cnt++;
            if (bus.usb_rd_state == 4'd3 && prev_state != 4'd3) begin
                chk_prev = chk_last;
                chk_last = cyc;
            end
            prev_rd_n  = bus.SLRD_n;
            prev_state = bus.usb_rd_state;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int limit);
        for (int k = 0; k < limit && bus.usb_rd_state != s; k++) tick();
        check("wait_state", 32'(bus.usb_rd_state), 32'(s));
    endtask

    task automatic wait_done(input int limit);
        int start;
        start = bd_cnt;
        for (int k = 0; k < limit && bd_cnt == start; k++) tick();
        check("burst_done_count", bd_cnt - start, 1);
    endtask

    int seq [4] = '{3, 4, 5, 6};
    int rd0, dv0, ab0, oe0, n_abort, start_bd;

    initial begin
        rst_n           = 1'b0;
        bus.USB3_FLAGA  = 1'b1;
        bus.cache_ready = 1'b1;
        repeat (3) tick();

        // Reset values while FLAGA is asserted
        check("rst_SLCS_n",     32'(bus.SLCS_n), 1);
        check("rst_SLOE_n",     32'(bus.SLOE_n), 1);
        check("rst_SLRD_n",     32'(bus.SLRD_n), 1);
        check("rst_FIFOADR",    32'(bus.FIFOADR), 3);
        check("rst_state",      32'(bus.usb_rd_state), 0);
        check("rst_data_out",   bus.data_out, 0);
        check("rst_data_valid", 32'(bus.data_valid), 0);
        check("rst_burst_done", 32'(bus.burst_done), 0);
        check("rst_rd_abort",   32'(bus.rd_abort), 0);

        // Release: start-up sequence then a full default burst
        rd0 = rd_low_cnt; dv0 = dv_cnt; ab0 = ab_cnt;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("start_state_seq", 32'(bus.usb_rd_state), seq[k]);
        end
        wait_done(B + 50);
        check("burst1_reads",  rd_low_cnt - rd0, B);
        check("burst1_valids", dv_cnt - dv0, B);
        check("burst1_abort",  ab_cnt - ab0, 0);
        check("burst1_q_empty", exp_q.size(), 0);

        // Back-to-back burst; cache_ready wiggles during the burst
        rd0 = rd_low_cnt; dv0 = dv_cnt;
        wait_state(4'd6, 50);
        check("burst_period", chk_last - chk_prev, 3 + B + LAT + GAP + 1);
        start_bd = bd_cnt;
        for (int k = 0; k < B + 50 && bd_cnt == start_bd; k++) begin
            bus.cache_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("burst2_done", bd_cnt - start_bd, 1);
        bus.USB3_FLAGA  = 1'b0;
        bus.cache_ready = 1'b1;
        check("burst2_reads",  rd_low_cnt - rd0, B);
        check("burst2_valids", dv_cnt - dv0, B);
        wait_state(4'd0, 20);

        // cache_ready low holds the block in IDLE
        bus.USB3_FLAGA  = 1'b1;
        bus.cache_ready = 1'b0;
        rd0 = rd_low_cnt;
        repeat ($urandom_range(20, 60)) begin
            tick();
            check("gated_idle", 32'(bus.usb_rd_state), 0);
        end
        check("gated_no_reads", rd_low_cnt - rd0, 0);
        bus.USB3_FLAGA  = 1'b0;
        bus.cache_ready = 1'b1;
        tick();

        // One-cycle FLAGA glitch
        oe0 = oe_low_cnt; rd0 = rd_low_cnt;
        bus.USB3_FLAGA = 1'b1;
        tick();
        check("glitch_chk", 32'(bus.usb_rd_state), 3);
        bus.USB3_FLAGA = 1'b0;
        repeat (6) tick();
        check("glitch_idle",   32'(bus.usb_rd_state), 0);
        check("glitch_no_oe",  oe_low_cnt - oe0, 0);
        check("glitch_no_rd",  rd_low_cnt - rd0, 0);
        check("glitch_cs_off", 32'(bus.SLCS_n), 1);

        // Mid-burst aborts, including one coinciding with the last word
        for (int it = 0; it < 4; it++) begin
            n_abort = (it == 0) ? 100 : (it == 3) ? B : int'($urandom_range(1, B - 1));
            rd0 = rd_low_cnt; dv0 = dv_cnt; ab0 = ab_cnt;
            bus.USB3_FLAGA = 1'b1;
            for (int k = 0; k < B + 50 && (rd_low_cnt - rd0) < n_abort; k++) tick();
            bus.USB3_FLAGA = 1'b0;
            tick();
            check("abort_drain_state", 32'(bus.usb_rd_state), 7);
            check("abort_pulse",       32'(bus.rd_abort), 1);
            wait_done(20);
            wait_state(4'd0, 20);
            repeat ($urandom_range(5, 15)) tick();
            check("abort_stay_idle", 32'(bus.usb_rd_state), 0);
            check("abort_reads",   rd_low_cnt - rd0, n_abort);
            check("abort_valids",  dv_cnt - dv0, n_abort);
            check("abort_count",   ab_cnt - ab0, 1);
            check("abort_q_empty", exp_q.size(), 0);
        end

        // Asynchronous reset during READ at word 50
        rd0 = rd_low_cnt;
        bus.USB3_FLAGA = 1'b1;
        for (int k = 0; k < B + 50 && (rd_low_cnt - rd0) < 50; k++) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_SLRD_n", 32'(bus.SLRD_n), 1);
        check("arst_SLOE_n", 32'(bus.SLOE_n), 1);
        check("arst_SLCS_n", 32'(bus.SLCS_n), 1);
        check("arst_state",  32'(bus.usb_rd_state), 0);
        check("arst_dv",     32'(bus.data_valid), 0);
        repeat (3) begin
            tick();
            check("arst_hold_dv", 32'(bus.data_valid), 0);
        end
        rd0 = rd_low_cnt; dv0 = dv_cnt;
        rst_n = 1'b1;
        wait_done(B + 50);
        bus.USB3_FLAGA = 1'b0;
        check("post_rst_reads",  rd_low_cnt - rd0, B);
        check("post_rst_valids", dv_cnt - dv0, B);
        check("post_rst_q_empty", exp_q.size(), 0);
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb3_slfifo_rd_ctrl.md
Name: usb3_slfifo_rd_ctrl

Overview:
- Synchronous read master for the FX3 slave FIFO interface; sits directly upstream of the RAM cache stage.
- Bursts 32-bit words out of the FX3 read socket whenever USB3_FLAGA reports data and the cache can accept a burst.
- Drives the FX3 strobes, presents captured words with a valid strobe, and exports usb_rd_state. The cache stage treats state code 6 as "burst in progress".

Parameters:
- BURST_LEN, 256, words per burst; power of two, 16..1024.
- RD_LATENCY, 2, cycles from SLRD_n low to valid data on USB3_DQ; range 1..3.
- GAP_CYCLES, 4, idle cycles after each burst before FLAGA is re-examined; ≥1.
- RD_SOCKET, 2'b11, value driven on FIFOADR.

Ports:
- clk  in  1  interface clock (same clock as the cache write side).
- rst_n  in  1  asynchronous reset, active low.
- USB3_FLAGA  in  1  FX3 read-socket data-available flag, active high.
- USB3_DQ  in  32  FX3 data bus.
- cache_ready  in  1  downstream can take a full burst; sampled only in IDLE.
- SLCS_n  out  1  chip select.
- SLOE_n  out  1  output enable.
- SLRD_n  out  1  read strobe.
- FIFOADR  out  2  socket address.
- usb_rd_state  out  4  registered current state code.
- data_out  out  32  captured word.
- data_valid  out  1  one-cycle strobe per captured word.
- burst_done  out  1  one-cycle pulse when a burst returns to GAP.
- rd_abort  out  1  one-cycle pulse when FLAGA drops mid-burst.

Behaviour:
- Clock and reset: all outputs are registered on the rising edge of clk. Reset is asynchronous, active low, and takes effect immediately.
- Reset values:
  - SLCS_n=1, SLOE_n=1, SLRD_n=1, FIFOADR=RD_SOCKET.
  - usb_rd_state=0, data_out=0.
  - data_valid, burst_done and rd_abort all 0.
  - All counters and the latency pipe cleared.
- Reset mid-burst: the burst is abandoned and no further data_valid is issued. After release the block starts in IDLE.
- State codes:
  - IDLE(0): all strobes high. If USB3_FLAGA=1 and cache_ready=1, go to CHK(3).
  - CHK(3): SLCS_n←0. If FLAGA=0, go to IDLE and release SLCS_n. Otherwise go to OE(4).
  - OE(4): SLOE_n←0; go to SETUP(5).
  - SETUP(5): SLRD_n←0; rd_cnt←0; go to READ(6).
  - READ(6): SLRD_n held low; rd_cnt increments every cycle.
    - When rd_cnt==BURST_LEN-1: SLRD_n←1 on the next edge; go to DRAIN(7).
    - If FLAGA=0 (the word asserted this cycle still counts): SLRD_n←1, pulse rd_abort, go to DRAIN.
    - The abort has priority when it coincides with the last word. Total reads stay ≤BURST_LEN and rd_abort still pulses.
  - DRAIN(7): SLOE_n and SLCS_n stay low for exactly RD_LATENCY cycles. Then go to GAP(8), pulse burst_done, and raise SLOE_n and SLCS_n.
  - GAP(8): wait GAP_CYCLES cycles, then go to IDLE.
  - Undefined codes go to IDLE.
- Read strobe count: a normal burst asserts SLRD_n low for exactly BURST_LEN cycles (SETUP edge through the last READ cycle).
- Capture pipe:
  - A shift register of length RD_LATENCY is loaded with the SLRD_n-active bit each cycle.
  - When its tail is 1: data_out←USB3_DQ and data_valid=1 in that cycle.
  - The first data_valid occurs RD_LATENCY cycles after the first SLRD_n-low cycle.
  - data_valid count per burst equals the number of SLRD_n-low cycles exactly, including on abort.
- Outputs held between strobes: data_out holds its value between valid strobes and is never cleared except by reset.
- cache_ready: ignored outside IDLE, so a burst, once started, always completes or aborts.
- Counter widths: rd_cnt is $clog2(BURST_LEN)+1 bits; GAP counter is $clog2(GAP_CYCLES)+1 bits. Neither wraps inside a burst.
- Back-to-back bursts: the minimum period between burst starts is 3 + BURST_LEN + RD_LATENCY + GAP_CYCLES + 1 cycles.

Test Plan:
- Reset value check: reset asserted with FLAGA=1 → all strobes high, usb_rd_state=0, no data_valid. After release with cache_ready=1 → state sequence 3,4,5,6.
- Normal burst, defaults: FX3 model with latency 2 driving an incrementing pattern → exactly 256 SLRD_n-low cycles and 256 data_valid pulses. data_out runs 0..255 in order. burst_done fires once, 2 cycles after SLRD_n rises.
- Mid-burst abort: FLAGA drops after 100 reads → 100 data_valid pulses, rd_abort pulses once, then DRAIN→GAP→IDLE. The next burst starts only after FLAGA=1 returns.
- cache_ready gating: FLAGA=1, cache_ready=0 → block stays in IDLE indefinitely. Dropping cache_ready during READ does not shorten the burst (256 words).
- Glitch flag: FLAGA=1 for exactly 1 cycle → CHK returns to IDLE, SLOE_n and SLRD_n never go low.
- Async reset during READ at word 50: strobes go high immediately, with no data_valid after reset. Re-running a 256-word burst then yields a correct 256 words.
